// File: rtl/int_pkg.sv
// int_pkg: shared defaults, level encoding, handler vectors and FSM states for the interrupt nesting controller.
package int_pkg;
  localparam int NSRC_DEF = 3;
  localparam int DEPTH_DEF = 3;
  localparam logic [1:0] LVL_NONE = 2'd0;
  localparam logic [31:0] VEC_IR1 = 32'h0000_0009;
  localparam logic [31:0] VEC_IR2 = 32'h0000_00c8;
  localparam logic [31:0] VEC_IR3 = 32'h0000_016c;
  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_SERVE} state_e;
  function automatic logic [31:0] vec_of(input logic [1:0] idx);
    return idx == 2'd0 ? VEC_IR1 : idx == 2'd1 ? VEC_IR2 : VEC_IR3;
  endfunction
endpackage

// File: rtl/int_sync.sv
// int_sync: 2-flop synchronizer plus rising-edge detect for one request line.
module int_sync (
  input  logic clk,
  input  logic CLR,
  input  logic d_i,
  output logic rise_o
);
  logic s1_q, s2_q, s3_q;
  logic [2:0] arm_q;
  always_ff @(posedge clk or negedge CLR) begin
    if (!CLR) begin
      s1_q  <= 1'b0;
      s2_q  <= 1'b0;
      s3_q  <= 1'b0;
      arm_q <= '0;
    end else begin
      s1_q  <= d_i;
      s2_q  <= s1_q;
      s3_q  <= s2_q;
      arm_q <= {arm_q[1:0], 1'b1};
    end
  end
  // edges are only trusted once s3 holds a real post-reset sample, so a line held high through reset is not a request
  assign rise_o = s2_q & ~s3_q & arm_q[2];
endmodule

// File: rtl/int_nest_ctrl.sv
// int_nest_ctrl: prioritized nested interrupt controller with level stack, masking and stall-aware redirect.
module int_nest_ctrl import int_pkg::*; #(
  parameter int NSRC  = NSRC_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic            clk,
  input  logic            CLR,
  input  logic [NSRC-1:0] ir,
  input  logic            eret,
  input  logic            stall,
  input  logic            mask_we,
  input  logic [NSRC-1:0] mask_wdata,
  output logic            Int,
  output logic [31:0]     Iaddr,
  output logic [1:0]      cur_lvl,
  output logic [1:0]      depth,
  output logic            ie,
  output logic [NSRC-1:0] pending,
  output logic [NSRC-1:0] mask,
  output logic            err
);
  localparam logic [1:0] DMAX = 2'(DEPTH);
  state_e state_q, state_d;
  logic [NSRC-1:0] pending_q, pending_d, mask_q, mask_d, rise, elig;
  logic [DEPTH-1:0][1:0] stack_q, stack_d;
  logic [1:0] lvl_q, lvl_d, depth_q, depth_d, win, win_q, win_d;
  logic [31:0] iaddr_q, iaddr_d;
  logic int_q, int_d, err_q, err_d, any_elig, issue, pop, accept;

  for (genvar i = 0; i < NSRC; i++) begin : g_sync
    int_sync u_sync (.clk(clk), .CLR(CLR), .d_i(ir[i]), .rise_o(rise[i]));
  end

  assign elig = pending_q & ~mask_q;
  always_comb begin
    win = '0;
    any_elig = 1'b0;
    for (int k = NSRC - 1; k >= 0; k--)
      if (elig[k]) begin
        win = 2'(k);
        any_elig = 1'b1;
      end
  end

  assign ie     = (state_q != ST_ISSUE) && (depth_q < DMAX);
  assign issue  = any_elig && ie && !eret && (lvl_q == LVL_NONE || win + 2'd1 < lvl_q);
  assign pop    = eret && depth_q != 2'd0;
  assign accept = state_q == ST_ISSUE && !stall;

  // pop is applied before push so an eret landing on the acceptance cycle nests correctly
  always_comb begin
    state_d   = state_q;
    lvl_d     = lvl_q;
    depth_d   = depth_q;
    stack_d   = stack_q;
    int_d     = int_q;
    iaddr_d   = iaddr_q;
    win_d     = win_q;
    pending_d = pending_q;
    err_d     = err_q | (eret && depth_q == 2'd0);
    mask_d    = mask_we ? mask_wdata : mask_q;
    if (pop) begin
      lvl_d   = stack_q[depth_q - 2'd1];
      depth_d = depth_q - 2'd1;
      if (state_q == ST_SERVE && depth_q == 2'd1) state_d = ST_IDLE;
    end
    if (accept) begin
      stack_d[depth_d]  = lvl_d;
      lvl_d             = win_q + 2'd1;
      depth_d           = depth_d + 2'd1;
      pending_d[win_q]  = 1'b0;
      int_d             = 1'b0;
      state_d           = ST_SERVE;
    end
    if (issue) begin
      state_d = ST_ISSUE;
      int_d   = 1'b1;
      iaddr_d = vec_of(win);
      win_d   = win;
    end
    pending_d = pending_d | rise;
  end

  always_ff @(posedge clk or negedge CLR) begin
    if (!CLR) begin
      state_q   <= ST_IDLE;
      lvl_q     <= LVL_NONE;
      depth_q   <= '0;
      stack_q   <= '0;
      int_q     <= 1'b0;
      iaddr_q   <= '0;
      win_q     <= '0;
      pending_q <= '0;
      mask_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      lvl_q     <= lvl_d;
      depth_q   <= depth_d;
      stack_q   <= stack_d;
      int_q     <= int_d;
      iaddr_q   <= iaddr_d;
      win_q     <= win_d;
      pending_q <= pending_d;
      mask_q    <= mask_d;
      err_q     <= err_d;
    end
  end

  assign Int     = int_q;
  assign Iaddr   = iaddr_q;
  assign cur_lvl = lvl_q;
  assign depth   = depth_q;
  assign pending = pending_q;
  assign mask    = mask_q;
  assign err     = err_q;
endmodule

// File: tb/tb_int_nest_ctrl.sv
// tb_int_nest_ctrl: directed scenario checks for the nested interrupt controller.
module tb_int_nest_ctrl;
  logic clk = 1'b0, CLR = 1'b0, eret = 1'b0, stall = 1'b0, mask_we = 1'b0;
  logic [2:0] ir = '0, mask_wdata = '0, pending, mask;
  logic Int, ie, err;
  logic [31:0] Iaddr;
  logic [1:0] cur_lvl, depth;
  int n_chk = 0, n_fail = 0;

  int_nest_ctrl dut (.clk(clk), .CLR(CLR), .ir(ir), .eret(eret), .stall(stall),
    .mask_we(mask_we), .mask_wdata(mask_wdata), .Int(Int), .Iaddr(Iaddr),
    .cur_lvl(cur_lvl), .depth(depth), .ie(ie), .pending(pending), .mask(mask), .err(err));

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse(input int idx);
    ir[idx] = 1'b1;
    tick(2);
    ir[idx] = 1'b0;
  endtask

  task automatic do_eret();
    eret = 1'b1;
    tick(1);
    eret = 1'b0;
  endtask

  task automatic test_reset();
    CLR = 1'b0;
    ir[0] = 1'b1;
    tick(2);
    n_chk++; if (Int !== 1'b0) begin n_fail++; $display("FAIL rst_int: got %b exp 0", Int); end
    n_chk++; if (Iaddr !== 32'h0) begin n_fail++; $display("FAIL rst_iaddr: got %h exp 0", Iaddr); end
    n_chk++; if ({cur_lvl, depth} !== 4'h0) begin n_fail++; $display("FAIL rst_lvl_depth: got %h exp 0", {cur_lvl, depth}); end
    n_chk++; if ({ie, err} !== 2'b10) begin n_fail++; $display("FAIL rst_ie_err: got %b exp 10", {ie, err}); end
    n_chk++; if ({pending, mask} !== 6'h0) begin n_fail++; $display("FAIL rst_pend_mask: got %h exp 0", {pending, mask}); end
    CLR = 1'b1;
    tick(6);
    n_chk++; if (pending !== 3'b000) begin n_fail++; $display("FAIL held_ir_no_edge: got %b exp 000", pending); end
    n_chk++; if (Int !== 1'b0) begin n_fail++; $display("FAIL held_ir_no_int: got %b exp 0", Int); end
    ir[0] = 1'b0;
    tick(4);
  endtask

  task automatic test_basic();
    pulse(1);
    tick(1);
    n_chk++; if (pending !== 3'b010) begin n_fail++; $display("FAIL basic_pend: got %b exp 010", pending); end
    n_chk++; if (Int !== 1'b0) begin n_fail++; $display("FAIL basic_int_early: got %b exp 0", Int); end
    tick(1);
    n_chk++; if (Int !== 1'b1) begin n_fail++; $display("FAIL basic_int: got %b exp 1", Int); end
    n_chk++; if (Iaddr !== 32'hc8) begin n_fail++; $display("FAIL basic_iaddr: got %h exp c8", Iaddr); end
    n_chk++; if (ie !== 1'b0) begin n_fail++; $display("FAIL basic_ie_issue: got %b exp 0", ie); end
    tick(1);
    n_chk++; if ({Int, cur_lvl, depth} !== {1'b0, 2'd2, 2'd1}) begin n_fail++; $display("FAIL basic_accept: got %b exp 01001", {Int, cur_lvl, depth}); end
    n_chk++; if (pending !== 3'b000) begin n_fail++; $display("FAIL basic_pend_clr: got %b exp 000", pending); end
    do_eret();
    n_chk++; if ({cur_lvl, depth, ie} !== 5'b00001) begin n_fail++; $display("FAIL basic_eret: got %b exp 00001", {cur_lvl, depth, ie}); end
  endtask

  task automatic test_nest();
    pulse(2);
    tick(2);
    n_chk++; if (Iaddr !== 32'h16c) begin n_fail++; $display("FAIL nest_iaddr3: got %h exp 16c", Iaddr); end
    tick(1);
    n_chk++; if ({cur_lvl, depth} !== {2'd3, 2'd1}) begin n_fail++; $display("FAIL nest_lvl3: got %b exp 1101", {cur_lvl, depth}); end
    pulse(0);
    tick(2);
    n_chk++; if ({Int, Iaddr} !== {1'b1, 32'h9}) begin n_fail++; $display("FAIL nest_preempt: got %b %h exp 1 9", Int, Iaddr); end
    tick(1);
    n_chk++; if ({cur_lvl, depth} !== {2'd1, 2'd2}) begin n_fail++; $display("FAIL nest_lvl1: got %b exp 0110", {cur_lvl, depth}); end
    do_eret();
    n_chk++; if ({cur_lvl, depth} !== {2'd3, 2'd1}) begin n_fail++; $display("FAIL nest_pop1: got %b exp 1101", {cur_lvl, depth}); end
    do_eret();
    n_chk++; if ({Int, cur_lvl, depth} !== 5'b0) begin n_fail++; $display("FAIL nest_pop2: got %b exp 00000", {Int, cur_lvl, depth}); end
  endtask

  task automatic test_no_preempt();
    pulse(0);
    tick(3);
    n_chk++; if (cur_lvl !== 2'd1) begin n_fail++; $display("FAIL np_serve1: got %0d exp 1", cur_lvl); end
    pulse(2);
    tick(1);
    n_chk++; if (pending !== 3'b100) begin n_fail++; $display("FAIL np_pend: got %b exp 100", pending); end
    tick(2);
    n_chk++; if ({Int, cur_lvl} !== {1'b0, 2'd1}) begin n_fail++; $display("FAIL np_no_int: got %b exp 001", {Int, cur_lvl}); end
    do_eret();
    n_chk++; if ({Int, cur_lvl, depth} !== 5'b0) begin n_fail++; $display("FAIL np_eret_wins: got %b exp 00000", {Int, cur_lvl, depth}); end
    tick(1);
    n_chk++; if ({Int, Iaddr} !== {1'b1, 32'h16c}) begin n_fail++; $display("FAIL np_issue3: got %b %h exp 1 16c", Int, Iaddr); end
    tick(1);
    do_eret();
  endtask

  task automatic test_stall();
    stall = 1'b1;
    pulse(1);
    tick(2);
    n_chk++; if ({Int, Iaddr} !== {1'b1, 32'hc8}) begin n_fail++; $display("FAIL st_int: got %b %h exp 1 c8", Int, Iaddr); end
    pulse(0);
    tick(3);
    n_chk++; if ({Int, Iaddr} !== {1'b1, 32'hc8}) begin n_fail++; $display("FAIL st_held: got %b %h exp 1 c8", Int, Iaddr); end
    n_chk++; if ({pending, depth} !== {3'b011, 2'd0}) begin n_fail++; $display("FAIL st_pend: got %b exp 01100", {pending, depth}); end
    stall = 1'b0;
    tick(1);
    n_chk++; if ({Int, cur_lvl, depth} !== {1'b0, 2'd2, 2'd1}) begin n_fail++; $display("FAIL st_accept: got %b exp 01001", {Int, cur_lvl, depth}); end
    tick(1);
    n_chk++; if ({Int, Iaddr} !== {1'b1, 32'h9}) begin n_fail++; $display("FAIL st_next: got %b %h exp 1 9", Int, Iaddr); end
    tick(1);
    do_eret();
    n_chk++; if ({cur_lvl, depth} !== {2'd2, 2'd1}) begin n_fail++; $display("FAIL st_pop: got %b exp 1001", {cur_lvl, depth}); end
    do_eret();
  endtask

  task automatic test_eret_in_issue();
    pulse(1);
    tick(3);
    stall = 1'b1;
    pulse(0);
    tick(2);
    n_chk++; if ({Int, Iaddr} !== {1'b1, 32'h9}) begin n_fail++; $display("FAIL ei_int: got %b %h exp 1 9", Int, Iaddr); end
    do_eret();
    n_chk++; if ({Int, cur_lvl, depth} !== 5'b10000) begin n_fail++; $display("FAIL ei_pop: got %b exp 10000", {Int, cur_lvl, depth}); end
    stall = 1'b0;
    tick(1);
    n_chk++; if ({Int, cur_lvl, depth} !== {1'b0, 2'd1, 2'd1}) begin n_fail++; $display("FAIL ei_accept: got %b exp 00101", {Int, cur_lvl, depth}); end
    do_eret();
  endtask

  task automatic test_mask();
    mask_we = 1'b1;
    mask_wdata = 3'b001;
    tick(1);
    mask_we = 1'b0;
    n_chk++; if (mask !== 3'b001) begin n_fail++; $display("FAIL mk_write: got %b exp 001", mask); end
    pulse(0);
    tick(3);
    n_chk++; if ({Int, pending} !== 4'b0001) begin n_fail++; $display("FAIL mk_blocked: got %b exp 0001", {Int, pending}); end
    stall = 1'b1;
    mask_we = 1'b1;
    mask_wdata = 3'b000;
    tick(1);
    mask_we = 1'b0;
    n_chk++; if ({Int, mask} !== 4'b0000) begin n_fail++; $display("FAIL mk_clear: got %b exp 0000", {Int, mask}); end
    tick(1);
    n_chk++; if ({Int, Iaddr} !== {1'b1, 32'h9}) begin n_fail++; $display("FAIL mk_int: got %b %h exp 1 9", Int, Iaddr); end
    mask_we = 1'b1;
    mask_wdata = 3'b001;
    tick(1);
    mask_we = 1'b0;
    n_chk++; if ({Int, Iaddr} !== {1'b1, 32'h9}) begin n_fail++; $display("FAIL mk_no_retract: got %b %h exp 1 9", Int, Iaddr); end
    stall = 1'b0;
    mask_we = 1'b1;
    mask_wdata = 3'b000;
    tick(1);
    mask_we = 1'b0;
    n_chk++; if ({Int, cur_lvl, depth} !== {1'b0, 2'd1, 2'd1}) begin n_fail++; $display("FAIL mk_accept: got %b exp 00101", {Int, cur_lvl, depth}); end
    do_eret();
  endtask

  task automatic test_depth_limit();
    pulse(2);
    tick(3);
    pulse(1);
    tick(3);
    pulse(0);
    tick(3);
    n_chk++; if ({cur_lvl, depth, ie} !== {2'd1, 2'd3, 1'b0}) begin n_fail++; $display("FAIL dl_full: got %b exp 01110", {cur_lvl, depth, ie}); end
    pulse(2);
    tick(3);
    n_chk++; if ({Int, pending} !== 4'b0100) begin n_fail++; $display("FAIL dl_pend: got %b exp 0100", {Int, pending}); end
    do_eret();
    n_chk++; if ({cur_lvl, depth} !== {2'd2, 2'd2}) begin n_fail++; $display("FAIL dl_pop1: got %b exp 1010", {cur_lvl, depth}); end
    do_eret();
    n_chk++; if ({Int, cur_lvl, depth} !== {1'b0, 2'd3, 2'd1}) begin n_fail++; $display("FAIL dl_pop2: got %b exp 01101", {Int, cur_lvl, depth}); end
    do_eret();
    tick(1);
    n_chk++; if ({Int, Iaddr} !== {1'b1, 32'h16c}) begin n_fail++; $display("FAIL dl_reissue: got %b %h exp 1 16c", Int, Iaddr); end
    tick(1);
    do_eret();
  endtask

  task automatic test_err_reset();
    n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL er_pre: got %b exp 0", err); end
    do_eret();
    n_chk++; if ({err, cur_lvl, depth, Int} !== 6'b100000) begin n_fail++; $display("FAIL er_set: got %b exp 100000", {err, cur_lvl, depth, Int}); end
    tick(2);
    n_chk++; if (err !== 1'b1) begin n_fail++; $display("FAIL er_sticky: got %b exp 1", err); end
    pulse(1);
    tick(3);
    pulse(2);
    tick(1);
    n_chk++; if ({cur_lvl, depth, pending} !== {2'd2, 2'd1, 3'b100}) begin n_fail++; $display("FAIL er_serve: got %b exp 1001100", {cur_lvl, depth, pending}); end
    #2 CLR = 1'b0;
    #1;
    n_chk++; if ({Int, cur_lvl, depth, err, ie} !== 7'b0000001) begin n_fail++; $display("FAIL er_async_rst: got %b exp 0000001", {Int, cur_lvl, depth, err, ie}); end
    n_chk++; if ({pending, mask, Iaddr} !== 38'h0) begin n_fail++; $display("FAIL er_async_rst2: got %h exp 0", {pending, mask, Iaddr}); end
    tick(2);
    CLR = 1'b1;
    tick(4);
    stall = 1'b1;
    pulse(0);
    tick(2);
    n_chk++; if (Int !== 1'b1) begin n_fail++; $display("FAIL er_issue: got %b exp 1", Int); end
    #2 CLR = 1'b0;
    #1;
    n_chk++; if ({Int, Iaddr, pending} !== 36'h0) begin n_fail++; $display("FAIL er_rst_issue: got %h exp 0", {Int, Iaddr, pending}); end
    tick(1);
    stall = 1'b0;
    CLR = 1'b1;
    tick(5);
    n_chk++; if ({Int, depth, cur_lvl} !== 5'b0) begin n_fail++; $display("FAIL er_discard: got %b exp 00000", {Int, depth, cur_lvl}); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_nest();
    test_no_preempt();
    test_stall();
    test_eret_in_issue();
    test_mask();
    test_depth_limit();
    test_err_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
